// File: rtl/arb_rr_out.sv
// Round-robin output-port arbiter with credit-based downstream flow control.
// Grant one cycle after request, one fixed idle bubble after packet end; transfers stall while credits are zero.
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module arb_rr_out #(
  parameter int NREQ    = 5,
  parameter int CREDITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      flit_id,
  input  logic            flit_vld,
  input  logic            credit_in,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      sel,
  output logic            fwd,
  output logic [2:0]      credit_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      credit_q, credit_d;

  logic            hi_found, lo_found, win_found;
  logic [2:0]      hi_idx, lo_idx, win_idx;
  logic            pkt_end;

  // Requesters above ptr take precedence over those at or below it (wrap-around search).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j] && (3'(j) > ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = 3'(j);
      end
      if (req[j] && (3'(j) <= ptr_q)) begin
        lo_found = 1'b1;
        lo_idx   = 3'(j);
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign fwd = (state_q == BUSY) & flit_vld & (credit_q != '0) & ~rst;

  // A header moving while the owner has already dropped req is a single-flit packet.
  assign pkt_end = fwd & ((flit_id == `TAIL) |
                          ((flit_id == `HEADER) & ~|(req & grant_q)));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (win_found) begin
        state_d = BUSY;
        grant_d = NREQ'(1) << win_idx;
        sel_d   = win_idx;
        ptr_d   = win_idx;
      end
    end else if (pkt_end) begin
      state_d = IDLE;
      grant_d = '0;
      sel_d   = '0;
    end
  end

  always_comb begin
    credit_d = credit_q;
    if (fwd && !credit_in) begin
      credit_d = credit_q - 3'd1;
    end else if (credit_in && !fwd && (credit_q != 3'(CREDITS))) begin
      credit_d = credit_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      ptr_q    <= 3'(NREQ - 1);
      credit_q <= 3'(CREDITS);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign grant      = grant_q;
  assign sel        = sel_q;
  assign credit_cnt = credit_q;

endmodule

// File: tb/tb_arb_rr_out.sv
// Randomized packet traffic against a packet-level arbiter model; a monitor compares every cycle's outputs.
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module tb_arb_rr_out;
  localparam int NREQ    = 5;
  localparam int CREDITS = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [2:0]      flit_id = '0;
  logic            flit_vld = 1'b0;
  logic            credit_in = 1'b0;
  logic [NREQ-1:0] grant;
  logic [2:0]      sel;
  logic            fwd;
  logic [2:0]      credit_cnt;

  arb_rr_out #(.NREQ(NREQ), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .flit_id    (flit_id),
    .flit_vld   (flit_vld),
    .credit_in  (credit_in),
    .grant      (grant),
    .sel        (sel),
    .fwd        (fwd),
    .credit_cnt (credit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] grant;
    logic [2:0]      sel;
    logic            fwd;
    logic [2:0]      cred;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Packet-level model: who owns the port, who won last, how many slots are free downstream.
  bit   m_busy;
  int   m_owner;
  int   m_last;
  int   m_cred;
  bit   pend[NREQ];
  int   len[NREQ];
  int   sent[NREQ];

  task automatic cycle(input bit r, input int cred_pct, input int vld_pct, input bit gen);
    logic [NREQ-1:0] rq;
    logic [2:0]      fid;
    exp_t            e;
    bit              vld, cin, f;
    int              bestd, w, d;
    @(negedge clk);
    cyc++;
    if (gen) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 99) < 20)) begin
          pend[i] = 1'b1;
          len[i]  = $urandom_range(1, 4);
          sent[i] = 0;
        end
      end
    end
    // A one-flit packet drops its request as soon as it owns the port.
    for (int i = 0; i < NREQ; i++)
      rq[i] = pend[i] && !(m_busy && (m_owner == i) && (len[i] == 1));
    vld = ($urandom_range(0, 99) < vld_pct);
    cin = ($urandom_range(0, 99) < cred_pct);
    if (m_busy) begin
      if (sent[m_owner] == 0)                    fid = `HEADER;
      else if (sent[m_owner] == len[m_owner] - 1) fid = `TAIL;
      else                                        fid = `PAYLOAD;
    end else begin
      fid = 3'($urandom_range(0, 7));
    end
    rst       = r;
    req       = rq;
    flit_vld  = vld;
    flit_id   = fid;
    credit_in = cin;

    f      = !r && m_busy && vld && (m_cred > 0);
    e.cyc  = cyc;
    if (r) begin
      e.grant = '0;
      e.sel   = '0;
      e.fwd   = 1'b0;
      e.cred  = 3'(CREDITS);
    end else begin
      e.grant = m_busy ? (NREQ'(1) << m_owner) : '0;
      e.sel   = m_busy ? 3'(m_owner) : 3'd0;
      e.fwd   = f;
      e.cred  = 3'(m_cred);
    end
    exp_q.push_back(e);

    if (r) begin
      m_busy = 1'b0;
      m_last = NREQ - 1;
      m_cred = CREDITS;
      for (int i = 0; i < NREQ; i++) begin
        pend[i] = 1'b0;
        sent[i] = 0;
      end
    end else begin
      m_cred = m_cred - (f ? 1 : 0) + (cin ? 1 : 0);
      if (m_cred > CREDITS) m_cred = CREDITS;
      if (m_busy) begin
        if (f) begin
          sent[m_owner]++;
          if (sent[m_owner] == len[m_owner]) begin
            pend[m_owner] = 1'b0;
            m_busy        = 1'b0;
          end
        end
      end else if (rq != '0) begin
        bestd = NREQ;
        w     = 0;
        for (int i = 0; i < NREQ; i++) begin
          d = (i - m_last - 1 + 2 * NREQ) % NREQ;
          if (rq[i] && (d < bestd)) begin
            bestd = d;
            w     = i;
          end
        end
        m_busy  = 1'b1;
        m_owner = w;
        m_last  = w;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if ((grant !== e.grant) || (sel !== e.sel) || (fwd !== e.fwd) || (credit_cnt !== e.cred)) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got grant=%b sel=%0d fwd=%b credit_cnt=%0d, want grant=%b sel=%0d fwd=%b credit_cnt=%0d",
                   e.cyc, grant, sel, fwd, credit_cnt, e.grant, e.sel, e.fwd, e.cred);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pcts[3];
    pcts[0] = 10;
    pcts[1] = 35;
    pcts[2] = 80;
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_cred  = CREDITS;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      len[i]  = 1;
      sent[i] = 0;
    end

    repeat (3) cycle(1'b1, 0, 0, 1'b0);

    // E, W, L request 4-flit packets; no credits return at first, so the port drains and stalls.
    pend[1] = 1'b1; len[1] = 4;
    pend[2] = 1'b1; len[2] = 4;
    pend[4] = 1'b1; len[4] = 4;
    repeat (16) cycle(1'b0, 0, 100, 1'b0);
    repeat (40) cycle(1'b0, 40, 100, 1'b0);

    for (int p = 0; p < 3; p++)
      repeat (800) cycle(1'b0, pcts[p], 70, 1'b1);

    // Reset in the middle of a packet, then everyone requests at once.
    for (int k = 0; (k < 200) && !(m_busy && (sent[m_owner] > 0)); k++)
      cycle(1'b0, 35, 70, 1'b1);
    repeat (2) cycle(1'b1, 35, 70, 1'b0);
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1;
      len[i]  = $urandom_range(1, 4);
      sent[i] = 0;
    end
    repeat (300) cycle(1'b0, 35, 70, 1'b1);

    @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_rr_out.md
ARB_RR_OUT -- requirements
Module: arb_rr_out

Interface
REQ-001 Parameter NREQ, default 5, meaning number of requesting input ports; bit order N=0, E=1, W=2, S=3, L=4.
REQ-002 Parameter CREDITS, default 4, meaning downstream buffer depth in flits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-input request for this output port (that input's LBDR port bit), level, held until granted packet completes.
REQ-006 flit_id  input  3  flit type of the flit currently offered by the granted input; encoded per the shared parameters include (`HEADER, `PAYLOAD, `TAIL).
REQ-007 flit_vld  input  1  granted input has a flit available this cycle.
REQ-008 credit_in  input  1  one-cycle pulse: downstream freed one buffer slot.
REQ-009 grant  output  NREQ  one-hot grant to the owning input; all-zero when idle.
REQ-010 sel  output  3  binary index of the granted input for the crossbar mux; 0 when idle.
REQ-011 fwd  output  1  flit transferred this cycle.
REQ-012 credit_cnt  output  3  available downstream credits.

Function
REQ-013 FSM states IDLE and BUSY; the block SHALL be in IDLE after reset.
REQ-014 IDLE: if any req bit set, SHALL pick winner by round-robin starting at index ptr+1 (mod NREQ), wrapping; register grant/sel next cycle and enter BUSY.
REQ-015 IDLE with req all-zero: SHALL stay in IDLE, grant=0, ptr unchanged.
REQ-016 On grant, ptr SHALL be set to the winner index so the winner has lowest priority next arbitration.
REQ-017 fwd SHALL be combinational: fwd = BUSY & flit_vld & (credit_cnt != 0).
REQ-018 BUSY: grant and sel SHALL remain constant until a flit with flit_id == `TAIL transfers (fwd=1); then next cycle SHALL be IDLE with grant=0.
REQ-019 Single-flit packet: a `HEADER flit transferring when the granted req bit is already 0 in the same cycle SHALL also end the packet (no-tail packet terminator).
REQ-020 Winner's req dropping in BUSY without a terminating transfer SHALL NOT release the grant.
REQ-021 Arbitration latency: req at cycle n in IDLE -> grant valid at cycle n+1; after TAIL at cycle m, IDLE at m+1, next grant at m+2 (one idle bubble, fixed).
REQ-022 credit_cnt SHALL decrement by 1 on fwd, increment by 1 on credit_in, unchanged when both occur in the same cycle.
REQ-023 credit_cnt SHALL saturate at CREDITS (extra credit_in ignored) and never underflow (fwd is blocked at 0).
REQ-024 flit_vld while credit_cnt == 0 SHALL stall: fwd=0, grant held, no state change.
REQ-025 grant SHALL be one-hot or zero at all times; sel SHALL equal the index of the set grant bit.

Reset
REQ-026 Assertion of rst at any time, including mid-packet, SHALL immediately force IDLE, grant=0, sel=0, ptr=NREQ-1 (so index 0 wins first), credit_cnt=CREDITS.
REQ-027 fwd SHALL be 0 while rst is high; first arbitration SHALL occur on the first posedge after rst deasserts.

Verification
REQ-028 Reset then req=5'b10110 -> next cycle grant=5'b00010, sel=1; after its TAIL, req unchanged -> grant=5'b00100, sel=2, then 5'b10000, sel=4, then 5'b00010.
REQ-029 Granted E, 4 flits (HEADER, PAYLOAD, PAYLOAD, TAIL) with no credit_in, CREDITS=4 -> fwd on all 4, credit_cnt 4->0, grant released after TAIL.
REQ-030 credit_cnt=0, flit_vld=1 for 3 cycles -> fwd=0, grant stable; credit_in pulse -> credit_cnt=1, fwd=1 on next offered flit.
REQ-031 Simultaneous fwd and credit_in at credit_cnt=2 -> stays 2; credit_in at credit_cnt=4 -> stays 4.
REQ-032 rst asserted mid-packet (BUSY, grant=5'b01000, credit_cnt=1) -> same cycle grant=0, sel=0, credit_cnt=4; after release req=5'b11111 -> grant=5'b00001.
REQ-033 Single-flit HEADER with winner req falling same cycle -> IDLE next cycle; winner req drop without transfer -> grant held.
